// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counting timer and its prescaler.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface down_counter_timer_if
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             underflow;
    logic             busy;

    modport master (
        output en, load, load_val, start, stop, auto_reload,
        input  q, zero, underflow, busy
    );

    modport slave (
        input  en, load, load_val, start, stop, auto_reload,
        output q, zero, underflow, busy
    );
endinterface

// File: rtl/down_counter_timer_tick_prescaler.sv
// Divides en-high cycles by PRESCALE; tick is high on the last cycle of each group.
module tick_prescaler
    import down_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int             CW   = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/down_counter_timer.sv
// Down-counting interval timer with one-shot / auto-reload modes.
// Define DOWN_COUNTER_PRESCALE_EN to divide en by PRESCALE before decrementing.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    down_counter_timer_if.slave bus
);
    if (WIDTH < 2) begin : g_bad_width
        $error("down_counter_timer: WIDTH must be >= 2");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("down_counter_timer: PRESCALE must be >= 1");
    end

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] reload;
    logic             underflow;
    logic             busy;
    logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
    // Prescaler only advances while running; any control action restarts its group.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load || bus.start || bus.stop),
        .en    (bus.en && (state == RUN)),
        .tick  (tick)
    );
`else
    assign tick = bus.en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            q         <= '0;
            reload    <= '0;
            underflow <= 1'b0;
            busy      <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (bus.load) begin
                q      <= bus.load_val;
                reload <= bus.load_val;
                state  <= bus.start ? RUN : IDLE;
                busy   <= bus.start;
            end else if (bus.stop) begin
                if (state == RUN) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (bus.start) begin
                // Resuming from IDLE keeps q; restarting after expiry reloads it.
                if (state == EXPIRED) begin
                    q <= reload;
                end
                state <= RUN;
                busy  <= 1'b1;
            end else if (state == RUN && tick) begin
                if (q != '0) begin
                    q <= q - 1'b1;
                end else begin
                    underflow <= 1'b1;
                    if (bus.auto_reload) begin
                        q <= reload;
                    end else begin
                        state <= EXPIRED;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.q         = q;
    assign bus.zero      = (q == '0);
    assign bus.underflow = underflow;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expected values.
module tb_down_counter_timer;
    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

    down_counter_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic ld, input logic [WIDTH-1:0] val, input logic st,
                        input logic sp, input logic e, input logic ar);
        bus.load        = ld;
        bus.load_val    = val;
        bus.start       = st;
        bus.stop        = sp;
        bus.en          = e;
        bus.auto_reload = ar;
    endtask

    task automatic expect_state(input string tag, input int eq, input int ebusy, input int euf);
        check({tag, ".q"}, 32'(bus.q), eq);
        check({tag, ".busy"}, 32'(bus.busy), ebusy);
        check({tag, ".uf"}, 32'(bus.underflow), euf);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        ctrl(0, 4'd0, 0, 0, 0, 0);
        step();
        step();
        expect_state("rst", 0, 0, 0);
        check("rst.zero", 32'(bus.zero), 1);
        @(negedge clk);
        reset = 1'b0;
        step();

`ifdef DOWN_COUNTER_PRESCALE_EN
        // Prescale 4: load 1 and start; four en cycles per decrement.
        ctrl(1, 4'd1, 1, 0, 1, 0);
        step();
        expect_state("ps.load", 1, 1, 0);
        ctrl(0, 4'd0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("ps.hold1", 1, 1, 0);
        end
        step();
        expect_state("ps.dec", 0, 1, 0);
        bus.en = 1'b0;
        step();
        step();
        expect_state("ps.en0", 0, 1, 0);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("ps.hold0", 0, 1, 0);
        end
        step();
        expect_state("ps.uf", 0, 0, 1);
`else
        // One-shot from 3.
        ctrl(1, 4'd3, 1, 0, 1, 0);
        step();
        expect_state("os.load", 3, 1, 0);
        ctrl(0, 4'd0, 0, 0, 1, 0);
        step(); expect_state("os.2", 2, 1, 0);
        step(); expect_state("os.1", 1, 1, 0);
        step(); expect_state("os.0", 0, 1, 0);
        check("os.zero", 32'(bus.zero), 1);
        step(); expect_state("os.uf", 0, 0, 1);
        step(); expect_state("os.exp", 0, 0, 0);
        step(); expect_state("os.exp2", 0, 0, 0);
        bus.start = 1'b1;
        step(); expect_state("os.restart", 3, 1, 0);
        bus.start = 1'b0;
        step(); expect_state("os.restart2", 2, 1, 0);

        // Auto-reload from 2: period of 3 ticks.
        ctrl(1, 4'd2, 1, 0, 1, 1);
        step();
        expect_state("ar.load", 2, 1, 0);
        ctrl(0, 4'd0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("ar.q", 32'(bus.q), (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
            check("ar.uf", 32'(bus.underflow), (i % 3 == 2) ? 1 : 0);
        end

        // Auto-reload from 0: underflow on every tick.
        ctrl(1, 4'd0, 1, 0, 1, 1);
        step();
        expect_state("ar0.load", 0, 1, 0);
        ctrl(0, 4'd0, 0, 0, 1, 1);
        step(); expect_state("ar0.t1", 0, 1, 1);
        step(); expect_state("ar0.t2", 0, 1, 1);

        // Pause and resume.
        ctrl(1, 4'd7, 1, 0, 1, 0);
        step();
        ctrl(0, 4'd0, 0, 0, 1, 0);
        step(); step(); step();
        expect_state("pr.4", 4, 1, 0);
        bus.stop = 1'b1;
        step(); expect_state("pr.stop", 4, 0, 0);
        bus.stop = 1'b0;
        step(); expect_state("pr.idle_en", 4, 0, 0);
        bus.start = 1'b1;
        step(); expect_state("pr.start", 4, 1, 0);
        bus.start = 1'b0;
        step(); expect_state("pr.3", 3, 1, 0);
        step(); expect_state("pr.2", 2, 1, 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(); expect_state("pr.both_run", 2, 0, 0);
        step(); expect_state("pr.both_idle", 2, 0, 0);
        bus.stop = 1'b0;
        step(); expect_state("pr.resume", 2, 1, 0);

        // Load wins over stop and start while running at q=2.
        ctrl(1, 4'd9, 1, 1, 1, 0);
        step(); expect_state("lp.load", 9, 1, 0);
        ctrl(0, 4'd0, 0, 0, 1, 0);
        step(); expect_state("lp.en1", 8, 1, 0);
        bus.en = 1'b0;
        step(); expect_state("lp.en0", 8, 1, 0);
        bus.en = 1'b1;
        step(); expect_state("lp.en1b", 7, 1, 0);

        // Asynchronous reset mid-count at q=5.
        ctrl(1, 4'd7, 1, 0, 1, 0);
        step();
        ctrl(0, 4'd0, 0, 0, 1, 0);
        step(); step();
        expect_state("ar.pre", 5, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        expect_state("arst", 0, 0, 0);
        check("arst.zero", 32'(bus.zero), 1);
        @(negedge clk);
        reset = 1'b0;
        step(); expect_state("arst.idle", 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end
endmodule
